// File: rtl/cdr_pkg.sv
// Shared CDR types and arithmetic helpers (sign, symmetric saturation).
// Pure definitions; no latency, no backpressure.
package cdr_pkg;

   localparam int NBIT = 6;
   localparam int NSEL = 2;

   typedef enum logic {ACQ, TRACK} cdr_state_t;
   typedef logic [NBIT+NSEL-1:0] phase_t;

   function automatic int sgn(input int v);
      if (v > 0) return 1;
      if (v < 0) return -1;
      return 0;
   endfunction

   function automatic int sat(input int v, input int lim);
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

endpackage

// File: rtl/cdr_vote_dec.sv
// Sums DEC early/late votes and strobes dec with d = sign(sum) on the DEC-th counted vote.
// Decision is combinational with the last vote; no backpressure, freeze holds the partial sum.
module cdr_vote_dec
   import cdr_pkg::*;
#(
   parameter int DEC = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              vld,
   input  logic              up,
   input  logic              dn,
   input  logic              freeze,
   output logic              dec,
   output logic signed [1:0] d
);

   localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int SW = $clog2(DEC + 1) + 1;

   logic [CW-1:0]        cnt;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] sum_nxt;
   logic signed [1:0]    e;
   logic                 cnt_en;

   always_comb begin
      cnt_en  = vld & ~freeze;
      e       = 2'sb00;
      if (up & ~dn)
         e = 2'sb01;
      else if (dn & ~up)
         e = 2'sb11;
      sum_nxt = sum + SW'(e);
      dec     = cnt_en && (cnt == CW'(DEC - 1));
      d       = 2'(sgn(int'(sum_nxt)));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
         sum <= '0;
      end else if (cnt_en) begin
         if (dec) begin
            cnt <= '0;
            sum <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            sum <= sum_nxt;
         end
      end
   end

endmodule

// File: rtl/cdr_phase_ctl.sv
// CDR loop filter: PI phase accumulator with ACQ->TRACK gain sequencing; ctl/sel/upd 1 cycle after the deciding vote.
// No backpressure: every vote is consumed; freeze holds all state and forces upd low.
module cdr_phase_ctl
   import cdr_pkg::*;
#(
   parameter int Nbit     = NBIT,
   parameter int Nsel     = NSEL,
   parameter int Nint     = 12,
   parameter int DEC      = 4,
   parameter int KP_ACQ   = 4,
   parameter int KP_TRK   = 1,
   parameter int KI_SHIFT = 4,
   parameter int ACQ_LEN  = 16,
   parameter int INIT     = 0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            vld,
   input  logic            up,
   input  logic            dn,
   input  logic            freeze,
   output logic [Nbit-1:0] ctl,
   output logic [Nsel-1:0] sel,
   output logic            upd,
   output logic            locked
);

   localparam int PW   = Nbit + Nsel;
   localparam int KPW  = $clog2(KP_ACQ) + 2;
   localparam int IPW  = Nint - KI_SHIFT + 1;
   localparam int STW  = (KPW > IPW) ? KPW : IPW;
   localparam int IMAX = 2**(Nint - 1) - 1;
   localparam int ACW  = $clog2(ACQ_LEN + 1);

   cdr_state_t           state, state_nxt;
   logic signed [Nint-1:0] integ, integ_nxt;
   logic [PW-1:0]        phase, phase_nxt;
   logic [ACW-1:0]       acq_cnt, acq_cnt_nxt;
   logic signed [STW-1:0] step;
   logic                 upd_nxt;
   logic                 dec;
   logic signed [1:0]    d;
   int                   integ_sum;
   int                   step_i;

   cdr_vote_dec #(.DEC(DEC)) u_vote (
      .clk    (clk),
      .rstn   (rstn),
      .vld    (vld),
      .up     (up),
      .dn     (dn),
      .freeze (freeze),
      .dec    (dec),
      .d      (d)
   );

   always_comb begin
      state_nxt   = state;
      integ_nxt   = integ;
      acq_cnt_nxt = acq_cnt;
      integ_sum   = int'(integ);
      step_i      = 0;
      if (dec) begin
         if (state == ACQ) begin
            step_i      = int'(d) * KP_ACQ;
            acq_cnt_nxt = acq_cnt + 1'b1;
            // Ties still count toward the acquisition window.
            if (acq_cnt == ACW'(ACQ_LEN - 1))
               state_nxt = TRACK;
         end else begin
            integ_sum = sat(int'(integ) + int'(d), IMAX);
            integ_nxt = Nint'(integ_sum);
            step_i    = int'(d) * KP_TRK + (integ_sum >>> KI_SHIFT);
         end
      end
      step      = STW'(step_i);
      phase_nxt = phase + PW'(step);
      upd_nxt   = (step != '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= ACQ;
         integ   <= '0;
         phase   <= PW'(INIT);
         acq_cnt <= '0;
         upd     <= 1'b0;
      end else begin
         state   <= state_nxt;
         integ   <= integ_nxt;
         phase   <= phase_nxt;
         acq_cnt <= acq_cnt_nxt;
         upd     <= upd_nxt;
      end
   end

   assign ctl    = phase[Nbit-1:0];
   assign sel    = phase[PW-1:Nbit];
   assign locked = (state == TRACK);

endmodule
